// File: rtl/i2c_axil_regs.sv
// i2c_axil_regs: AXI4-Lite slave with four 32-bit registers for the I2C core; define I2C_AXIL_SLVERR_EN for SLVERR on out-of-range accesses.
module i2c_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
`ifdef I2C_AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif
    logic            rdy_q, rdy_d;
    logic            aw_full_q, aw_full_d;
    logic [2:0]      aw_idx_q, aw_idx_d;
    logic            w_full_q, w_full_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [DW/8-1:0] w_strb_q, w_strb_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];
    logic            aw_hs, w_hs, ar_hs, commit;
    logic [2:0]      ar_idx;
    logic            unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR, ARADDR};
    // rdy_q keeps every READY low during reset and for the first edge after it
    assign AWREADY = rdy_q & ~aw_full_q & ~bvalid_q;
    assign WREADY  = rdy_q & ~w_full_q & ~bvalid_q;
    assign ARREADY = rdy_q & ~rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign REG0    = regs_q[0];
    assign REG1    = regs_q[1];
    assign REG2    = regs_q[2];
    assign REG3    = regs_q[3];
    always_comb begin
        aw_hs     = AWVALID & AWREADY;
        w_hs      = WVALID & WREADY;
        ar_hs     = ARVALID & ARREADY;
        ar_idx    = ARADDR[4:2];
        commit    = aw_full_q & w_full_q;
        rdy_d     = 1'b1;
        aw_full_d = ~commit & (aw_full_q | aw_hs);
        aw_idx_d  = aw_hs ? AWADDR[4:2] : aw_idx_q;
        w_full_d  = ~commit & (w_full_q | w_hs);
        w_data_d  = w_hs ? WDATA : w_data_q;
        w_strb_d  = w_hs ? WSTRB : w_strb_q;
        bvalid_d  = commit | (bvalid_q & ~BREADY);
        bresp_d   = commit ? (aw_idx_q[2] ? OOR_RESP : 2'b00) : bresp_q;
        rvalid_d  = ar_hs | (rvalid_q & ~RREADY);
        rdata_d   = ar_hs ? (ar_idx[2] ? '0 : regs_q[ar_idx[1:0]]) : rdata_q;
        rresp_d   = ar_hs ? (ar_idx[2] ? OOR_RESP : 2'b00) : rresp_q;
        regs_d    = regs_q;
        if (commit && !aw_idx_q[2])
            for (int k = 0; k < DW/8; k++)
                if (w_strb_q[k]) regs_d[aw_idx_q[1:0]][8*k +: 8] = w_data_q[8*k +: 8];
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_q     <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            regs_q    <= '{default: '0};
        end else begin
            rdy_q     <= rdy_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_i2c_axil_regs.sv
// tb_i2c_axil_regs: directed scoreboard bench for the i2c_axil_regs AXI4-Lite register block.
module tb_i2c_axil_regs;
`ifdef I2C_AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif
    logic        ACLK, ARESETN;
    logic [4:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA, REG0, REG1, REG2, REG3;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] rd_q [$];
    logic [1:0]  rr_q [$];
    logic [1:0]  b_q  [$];

    i2c_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_b();
        int n = 0;
        while (!BVALID && n < 20) begin
            step();
            n++;
        end
        check("b_timeout", BVALID, 1);
        check("bresp", BRESP, b_q.pop_front());
        step();
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        bit aw_go, w_go;
        int n = 0;
        b_q.push_back(er);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        while ((AWVALID || WVALID) && n < 20) begin
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            step();
            if (aw_go) AWVALID = 0;
            if (w_go) WVALID = 0;
            n++;
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit go;
        int n = 0;
        rd_q.push_back(ed);
        rr_q.push_back(er);
        ARADDR = a; ARVALID = 1;
        while (ARVALID && n < 20) begin
            go = ARREADY;
            step();
            if (go) ARVALID = 0;
            n++;
        end
        n = 0;
        while (!RVALID && n < 20) begin
            step();
            n++;
        end
        check("r_timeout", RVALID, 1);
        check("rdata", RDATA, rd_q.pop_front());
        check("rresp", RRESP, rr_q.pop_front());
        step();
    endtask

    initial begin
        ARESETN = 0; AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
        AWVALID = 0; WVALID = 0; ARVALID = 0; WDATA = 0; WSTRB = 0;
        BREADY = 1; RREADY = 1;
        repeat (3) step();
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_reg0", REG0, 0);
        ARESETN = 1;
        #1;
        check("post_rst_pre_edge_awready", AWREADY, 0);
        step();
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_wready", WREADY, 1);
        check("post_rst_arready", ARREADY, 1);
        // Basic write/readback of all four registers
        for (int i = 0; i < 4; i++) axi_write(5'(4*i), 32'(i+1), 4'hF, 2'b00);
        for (int i = 0; i < 4; i++) axi_read(5'(4*i), 32'(i+1), 2'b00);
        // Byte-lane strobes
        axi_write(5'h04, 32'h11111111, 4'hF, 2'b00);
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, 2'b00);
        axi_read(5'h04, 32'h11BB11DD, 2'b00);
        check("reg1_strb", REG1, 32'h11BB11DD);
        axi_write(5'h08, 32'hFFFFFFFF, 4'h0, 2'b00);
        check("reg2_nostrb", REG2, 32'h3);
        // Read and write commit to REG3 on the same edge: read sees old value
        b_q.push_back(2'b00);
        AWADDR = 5'h0C; WDATA = 32'h44; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        step();
        AWVALID = 0; WVALID = 0; ARADDR = 5'h0C; ARVALID = 1;
        step();
        ARVALID = 0;
        check("same_edge_bvalid", BVALID, 1);
        check("same_edge_bresp", BRESP, b_q.pop_front());
        check("same_edge_rvalid", RVALID, 1);
        check("same_edge_rdata_old", RDATA, 32'h4);
        check("same_edge_reg3", REG3, 32'h44);
        step();
        // W three cycles before AW
        b_q.push_back(2'b00);
        WDATA = 32'h101; WSTRB = 4'hF; WVALID = 1;
        check("w_first_wready", WREADY, 1);
        step();
        WVALID = 0;
        repeat (2) step();
        check("w_first_no_b", BVALID, 0);
        AWADDR = 5'h00; AWVALID = 1;
        check("w_first_awready", AWREADY, 1);
        step();
        AWVALID = 0;
        check("w_first_b_not_yet", BVALID, 0);
        step();
        check("w_first_b_rise", BVALID, 1);
        check("w_first_bresp", BRESP, b_q.pop_front());
        step();
        check("w_first_reg0", REG0, 32'h101);
        // BREADY held low for five cycles
        BREADY = 0;
        b_q.push_back(2'b00);
        AWADDR = 5'h0C; WDATA = 32'h77; WSTRB = 4'b0001; AWVALID = 1; WVALID = 1;
        step();
        AWVALID = 0; WVALID = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bstall_bvalid", BVALID, 1);
            check("bstall_awready", AWREADY, 0);
            check("bstall_wready", WREADY, 0);
            if (i < 4) step();
        end
        check("bstall_bresp", BRESP, b_q.pop_front());
        BREADY = 1;
        step();
        check("bstall_release_bvalid", BVALID, 0);
        check("bstall_release_awready", AWREADY, 1);
        check("bstall_reg3", REG3, 32'h77);
        // Out-of-range access
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, OOR);
        axi_read(5'h14, 32'h0, OOR);
        check("oor_reg0", REG0, 32'h101);
        check("oor_reg1", REG1, 32'h11BB11DD);
        check("oor_reg2", REG2, 32'h3);
        check("oor_reg3", REG3, 32'h77);
        // Asynchronous reset while a response is pending
        BREADY = 0;
        AWADDR = 5'h08; WDATA = 32'h3; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        step();
        AWVALID = 0; WVALID = 0;
        step();
        check("pre_rst_bvalid", BVALID, 1);
        check("pre_rst_reg2", REG2, 32'h3);
        #2 ARESETN = 0;
        #1;
        check("async_rst_bvalid", BVALID, 0);
        check("async_rst_reg2", REG2, 0);
        check("async_rst_awready", AWREADY, 0);
        #1 ARESETN = 1; BREADY = 1;
        step();
        check("rerst_awready", AWREADY, 1);
        check("rerst_bvalid", BVALID, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_axil_regs.md
I2C_AXIL_REGS -- requirements
Module: i2c_axil_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width (only 32 is supported).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, the byte-address width.
REQ-003 The block SHALL have port ACLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port ARESETN, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have the write-address ports: AWADDR in ADDR_WIDTH; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1.
REQ-006 The block SHALL have the write-data ports: WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1.
REQ-007 The block SHALL have the write-response ports: BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 The block SHALL have the read-address ports: ARADDR in ADDR_WIDTH; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1.
REQ-009 The block SHALL have the read-data ports: RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-010 The block SHALL have port REG0..REG3, output, 32 bits each, the live register contents for the I2C core.

Function
REQ-011 The block SHALL decode the register index as ADDR[4:2] and ignore ADDR[1:0]; indices 0-3 (0x00-0x0C) are in range and 4-7 (0x10-0x1C) are out of range.
REQ-012 The block SHALL capture AW and W independently in one-entry holds; AWREADY=1 iff the AW hold is empty and BVALID=0, and WREADY=1 iff the W hold is empty and BVALID=0.
REQ-013 The block SHALL, on the first edge at which both holds are full, commit the write, clear both holds and set BVALID=1 at that edge: latency is 1 cycle after the later of the AW/W handshakes.
REQ-014 The block SHALL perform the write per byte lane: byte k updated from WDATA[8k+7:8k] iff WSTRB[k]=1; WSTRB=0 changes nothing but still yields a response.
REQ-015 The block SHALL hold BVALID and BRESP stable until BREADY=1 is sampled, and SHALL NOT accept any further AW/W until that response completes.
REQ-016 The block SHALL set ARREADY=1 iff RVALID=0; at an AR handshake edge it SHALL register RDATA/RRESP and set RVALID=1 (1-cycle latency), holding them stable until RREADY=1 is sampled.
REQ-017 The block SHALL run the read and write paths concurrently; a read and a write committing to the same register on the same edge SHALL return the pre-write value.
REQ-018 The block SHALL return RDATA=0 for out-of-range reads and SHALL ignore out-of-range writes (no register changes).
REQ-019 The block SHALL drive BRESP/RRESP as OKAY (2'b00) except as stated in REQ-024.
REQ-020 The block SHALL drive REG0..REG3 directly from the register flops with no added latency.

Reset
REQ-021 While ARESETN=0, the block SHALL force REG0..REG3=0, RDATA=0, BRESP=RRESP=0, BVALID=RVALID=0 and AWREADY=WREADY=ARREADY=0, and SHALL clear both holds.
REQ-022 The block SHALL drive AWREADY, WREADY and ARREADY to 1 at the first rising edge after ARESETN deasserts; a transaction in flight at reset SHALL be discarded without a response.

Configuration
REQ-023 The block SHALL be controlled by the macro I2C_AXIL_SLVERR_EN, which selects the response code for out-of-range accesses.
REQ-024 When I2C_AXIL_SLVERR_EN is defined, the block SHALL answer out-of-range accesses with BRESP/RRESP=SLVERR (2'b10); when it is undefined, they SHALL receive OKAY. REQ-018 applies in both cases.

Verification
REQ-025 The bench SHALL write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C with WSTRB=0xF, then read them back -> RDATA 0x1..0x4 and all responses OKAY.
REQ-026 The bench SHALL write 0x11111111 to 0x04 and then 0xAABBCCDD to 0x04 with WSTRB=0b0101 -> reading 0x04 returns 0x11BB11DD and REG1=0x11BB11DD.
REQ-027 The bench SHALL present W 3 cycles before AW -> W is accepted immediately, and BVALID rises exactly 1 cycle after the AW handshake.
REQ-028 The bench SHALL hold BREADY low for 5 cycles after a write -> BVALID stays 1, and AWREADY/WREADY stay 0 until the B handshake.
REQ-029 The bench SHALL write 0xDEADBEEF to 0x14 and then read 0x14 -> RDATA=0 and REG0..REG3 unchanged; BRESP/RRESP=2'b10 with I2C_AXIL_SLVERR_EN defined and 2'b00 without it.
REQ-030 The bench SHALL assert ARESETN low while BVALID=1 and REG2=0x3 -> BVALID=0 and REG2=0 immediately (asynchronously), and AWREADY=1 at the first edge after release.
